// File: rtl/aes_subbytes_iter.sv
// aes_subbytes_iter: iterative AES SubBytes, LANES 32-bit columns substituted per cycle
module aes_subbytes_iter #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("aes_subbytes_iter: LANES must be 1, 2 or 4");
    end

    // FIPS-197 forward S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q;
    logic [1:0]           col_cnt_q;
    logic [1:0]           col_cnt_d;
    logic [127:0]         work_q;
    logic [127:0]         res_q;
    logic [6:0]           col_msb;
    logic [LANES*32-1:0]  col_in;
    logic [LANES*32-1:0]  col_sub;
    logic                 last;

    // Columns col_cnt .. col_cnt+LANES-1 form one contiguous slice since col_cnt is a multiple of LANES
    assign col_msb   = 7'd127 - {col_cnt_q, 5'd0};
    assign col_in    = work_q[col_msb -: LANES*32];
    assign col_cnt_d = col_cnt_q + 2'(LANES);
    assign last      = (col_cnt_q == 2'(4 - LANES));

    for (genvar i = 0; i < LANES * 4; i++) begin : g_sbox
        assign col_sub[8*i +: 8] = SBOX[11'd2047 - {col_in[8*i +: 8], 3'd0} -: 8];
    end

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_state = res_q;

    // Control FSM: capture in IDLE, substitute LANES columns per BUSY cycle, hold result in DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            work_q    <= '0;
            res_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    work_q    <= in_state;
                    col_cnt_q <= '0;
                    state_q   <= BUSY;
                end
                BUSY: begin
                    res_q[col_msb -: LANES*32] <= col_sub;
                    if (last) state_q <= DONE;
                    else col_cnt_q <= col_cnt_d;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_subbytes_iter.sv
// tb_aes_subbytes_iter: checks LANES=1,2,4 instances against a GF(2^8)-derived S-box model
module tb_aes_subbytes_iter;
    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [2:0]           in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0][127:0]    in_state, out_state;
    logic [7:0]           sb [256];
    int                   pass_cnt = 0;
    int                   total_cnt = 0;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t tbl [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_subbytes_iter #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[s[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic wait_done(input int k, output int e);
        e = 0;
        while (!out_valid[k] && e < 20) begin
            @(negedge clk);
            e++;
        end
    endtask

    // One transaction: accept, measure latency, check result, handshake, check hold afterwards
    task automatic xfer(input int k, input logic [127:0] din, input logic [127:0] exp, input string nm);
        int e;
        chk($sformatf("%s L%0d in_ready", nm, 1 << k), 128'(in_ready[k]), 128'd1);
        in_state[k] = din;
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_state[k] = ~din;
        wait_done(k, e);
        chk($sformatf("%s L%0d latency", nm, 1 << k), 128'(e), 128'(4 >> k));
        chk($sformatf("%s L%0d data", nm, 1 << k), out_state[k], exp);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        chk($sformatf("%s L%0d valid drop", nm, 1 << k), 128'(out_valid[k]), 128'd0);
        chk($sformatf("%s L%0d idle ready", nm, 1 << k), 128'(in_ready[k]), 128'd1);
        chk($sformatf("%s L%0d data kept", nm, 1 << k), out_state[k], exp);
    endtask

    task automatic backpressure(input int k, input logic [127:0] a, input logic [127:0] c);
        int e;
        in_state[k] = a;
        in_valid[k] = 1'b1;
        out_ready[k] = 1'b0;
        @(negedge clk);
        in_valid[k] = 1'b0;
        wait_done(k, e);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp L%0d valid %0d", 1 << k, i), 128'(out_valid[k]), 128'd1);
            chk($sformatf("bp L%0d data %0d", 1 << k, i), out_state[k], model(a));
            chk($sformatf("bp L%0d in_ready %0d", 1 << k, i), 128'(in_ready[k]), 128'd0);
            in_valid[k] = (i == 3);
            in_state[k] = c;
            @(negedge clk);
        end
        in_valid[k] = 1'b1;
        out_ready[k] = 1'b1;
        @(negedge clk);
        chk($sformatf("bp L%0d no accept in DONE", 1 << k), 128'(busy[k]), 128'd0);
        chk($sformatf("bp L%0d idle ready", 1 << k), 128'(in_ready[k]), 128'd1);
        chk($sformatf("bp L%0d valid drop", 1 << k), 128'(out_valid[k]), 128'd0);
        @(negedge clk);
        in_valid[k] = 1'b0;
        chk($sformatf("bp L%0d accept after idle", 1 << k), 128'(busy[k]), 128'd1);
        wait_done(k, e);
        chk($sformatf("bp L%0d next data", 1 << k), out_state[k], model(c));
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic back_to_back(input int k, input logic [127:0] a, input logic [127:0] b);
        int acc [$];
        logic [127:0] res [$];
        in_state[k] = a;
        in_valid[k] = 1'b1;
        out_ready[k] = 1'b1;
        for (int c = 0; c < 3 * ((4 >> k) + 2) + 6; c++) begin
            if (out_valid[k]) res.push_back(out_state[k]);
            if (in_valid[k] && in_ready[k]) acc.push_back(c);
            @(negedge clk);
            if (acc.size() == 1) in_state[k] = b;
            if (acc.size() >= 2) in_valid[k] = 1'b0;
        end
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b0;
        chk($sformatf("b2b L%0d accepts", 1 << k), 128'(acc.size()), 128'd2);
        chk($sformatf("b2b L%0d spacing", 1 << k), acc.size() >= 2 ? 128'(acc[1] - acc[0]) : 128'd0,
            128'((4 >> k) + 2));
        chk($sformatf("b2b L%0d results", 1 << k), 128'(res.size()), 128'd2);
        chk($sformatf("b2b L%0d first", 1 << k), res.size() >= 1 ? res[0] : 128'hx, model(a));
        chk($sformatf("b2b L%0d second", 1 << k), res.size() >= 2 ? res[1] : 128'hx, model(b));
    endtask

    task automatic reset_busy(input int k, input logic [127:0] a);
        in_state[k] = a;
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        if (k < 2) @(negedge clk);
        chk($sformatf("rst L%0d busy before", 1 << k), 128'(busy[k]), 128'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk($sformatf("rst L%0d valid", 1 << k), 128'(out_valid[k]), 128'd0);
        chk($sformatf("rst L%0d busy", 1 << k), 128'(busy[k]), 128'd0);
        chk($sformatf("rst L%0d data", 1 << k), out_state[k], 128'd0);
        chk($sformatf("rst L%0d in_ready low", 1 << k), 128'(in_ready[k]), 128'd0);
        rst_n = 1'b1;
        #1;
        chk($sformatf("rst L%0d in_ready", 1 << k), 128'(in_ready[k]), 128'd1);
        @(negedge clk);
        begin
            logic [127:0] v = rnd128();
            xfer(k, v, model(v), "post-rst");
        end
    endtask

    initial begin
        in_valid = '0;
        out_ready = '0;
        in_state = '0;
        rst_n = 1'b0;
        build_sbox();
        tbl[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
        tbl[1] = '{128'h0, {16{8'h63}}};
        tbl[2] = '{{16{8'hff}}, {16{8'h16}}};
        tbl[3] = '{{16{8'h53}}, {16{8'hed}}};
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset L%0d valid", 1 << k), 128'(out_valid[k]), 128'd0);
            chk($sformatf("reset L%0d busy", 1 << k), 128'(busy[k]), 128'd0);
            chk($sformatf("reset L%0d data", 1 << k), out_state[k], 128'd0);
            chk($sformatf("reset L%0d in_ready", 1 << k), 128'(in_ready[k]), 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                xfer(k, tbl[i].din, tbl[i].dout, $sformatf("vec%0d", i));
                if (i == 0)
                    chk($sformatf("shiftrows L%0d", 1 << k), shift_rows(out_state[k]),
                        128'hd4bf5d30e0b452aeb84111f11e2798e5);
            end
            for (int i = 0; i < 20; i++) begin
                logic [127:0] v = rnd128();
                xfer(k, v, model(v), $sformatf("rand%0d", i));
            end
            backpressure(k, rnd128(), rnd128());
            back_to_back(k, rnd128(), rnd128());
            reset_busy(k, rnd128());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
